// File: rtl/rx_tcp_pseudo_hdr_prepend.sv
// rtl/rx_tcp_pseudo_hdr_prepend.sv - prepends the TCP checksum pseudo header to an RX segment stream
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif
`ifndef TOT_LEN_W
`define TOT_LEN_W 16
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 256
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 5
`endif

module rx_tcp_pseudo_hdr_prepend #(
    parameter int DATA_WIDTH = `MAC_INTERFACE_W,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        src_pseudo_rx_hdr_val,
    output logic                        pseudo_src_rx_hdr_rdy,
    input  logic [`IP_ADDR_W-1:0]       src_pseudo_rx_src_ip,
    input  logic [`IP_ADDR_W-1:0]       src_pseudo_rx_dst_ip,
    input  logic [`TOT_LEN_W-1:0]       src_pseudo_rx_tcp_tot_len,
    input  logic                        src_pseudo_rx_data_val,
    output logic                        pseudo_src_rx_data_rdy,
    input  logic [DATA_WIDTH-1:0]       src_pseudo_rx_data,
    input  logic                        src_pseudo_rx_last,
    input  logic [`MAC_PADBYTES_W-1:0]  src_pseudo_rx_padbytes,
    output logic [DATA_WIDTH-1:0]       pseudo_dst_tdata,
    output logic [KEEP_WIDTH-1:0]       pseudo_dst_tkeep,
    output logic                        pseudo_dst_tval,
    input  logic                        dst_pseudo_trdy,
    output logic                        pseudo_dst_tlast
);
    localparam int P  = 12;
    localparam int PW = P * 8;
    localparam int LB = KEEP_WIDTH - P;
    localparam int LW = LB * 8;
    localparam int CW = $clog2(KEEP_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, FIRST, BODY, TAIL} state_t;

    state_t                  state_q, state_d;
    logic [`IP_ADDR_W-1:0]   src_ip_q, src_ip_d;
    logic [`IP_ADDR_W-1:0]   dst_ip_q, dst_ip_d;
    logic [`TOT_LEN_W-1:0]   tot_len_q, tot_len_d;
    logic [PW-1:0]           carry_q, carry_d;
    logic [CW-1:0]           carry_bytes_q, carry_bytes_d;

    logic [PW-1:0]           pseudo_hdr;
    logic [CW-1:0]           valid_bytes;
    logic                    short_last;
    logic                    beat;
    logic [DATA_WIDTH-1:0]   raw_data;
    logic [KEEP_WIDTH-1:0]   keep;

    function automatic logic [KEEP_WIDTH-1:0] keep_top(input logic [CW-1:0] n);
        keep_top = ~({KEEP_WIDTH{1'b1}} >> n);
    endfunction

    assign pseudo_hdr  = {src_ip_q[31:0], dst_ip_q[31:0], 8'h00, 8'h06, tot_len_q[15:0]};
    assign valid_bytes = CW'(KEEP_WIDTH) - CW'(src_pseudo_rx_padbytes);
    // A last line that fits beside the leading P bytes ends the segment without a TAIL beat
    assign short_last  = src_pseudo_rx_last && (valid_bytes <= CW'(LB));
    assign beat        = src_pseudo_rx_data_val && dst_pseudo_trdy;

    always_comb begin
        state_d                = state_q;
        src_ip_d               = src_ip_q;
        dst_ip_d               = dst_ip_q;
        tot_len_d              = tot_len_q;
        carry_d                = carry_q;
        carry_bytes_d          = carry_bytes_q;
        pseudo_src_rx_hdr_rdy  = 1'b0;
        pseudo_src_rx_data_rdy = 1'b0;
        pseudo_dst_tval        = 1'b0;
        pseudo_dst_tlast       = 1'b0;
        raw_data               = '0;
        keep                   = '0;
        case (state_q)
            IDLE: begin
                pseudo_src_rx_hdr_rdy = 1'b1;
                if (src_pseudo_rx_hdr_val) begin
                    src_ip_d  = src_pseudo_rx_src_ip;
                    dst_ip_d  = src_pseudo_rx_dst_ip;
                    tot_len_d = src_pseudo_rx_tcp_tot_len;
                    state_d   = FIRST;
                end
            end
            FIRST, BODY: begin
                pseudo_src_rx_data_rdy = dst_pseudo_trdy;
                pseudo_dst_tval        = src_pseudo_rx_data_val;
                raw_data = {(state_q == FIRST) ? pseudo_hdr : carry_q,
                            src_pseudo_rx_data[DATA_WIDTH-1 -: LW]};
                keep     = '1;
                if (short_last) begin
                    keep             = keep_top(CW'(P) + valid_bytes);
                    pseudo_dst_tlast = 1'b1;
                end
                if (beat) begin
                    carry_d = src_pseudo_rx_data[PW-1:0];
                    if (!src_pseudo_rx_last) begin
                        state_d = BODY;
                    end else if (short_last) begin
                        state_d = IDLE;
                    end else begin
                        carry_bytes_d = valid_bytes - CW'(LB);
                        state_d       = TAIL;
                    end
                end
            end
            TAIL: begin
                pseudo_dst_tval  = 1'b1;
                pseudo_dst_tlast = 1'b1;
                raw_data         = {carry_q, {LW{1'b0}}};
                keep             = keep_top(carry_bytes_q);
                if (dst_pseudo_trdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d                = state_t'('x);
                pseudo_src_rx_hdr_rdy  = 1'bx;
                pseudo_src_rx_data_rdy = 1'bx;
                pseudo_dst_tval        = 1'bx;
                pseudo_dst_tlast       = 1'bx;
                raw_data               = 'x;
                keep                   = 'x;
            end
        endcase
    end

    // Bytes outside tkeep are forced to zero so pad garbage never leaks downstream
    always_comb begin
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            pseudo_dst_tdata[i*8 +: 8] = keep[i] ? raw_data[i*8 +: 8] : 8'h00;
        end
    end
    assign pseudo_dst_tkeep = keep;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            src_ip_q      <= '0;
            dst_ip_q      <= '0;
            tot_len_q     <= '0;
            carry_q       <= '0;
            carry_bytes_q <= '0;
        end else begin
            state_q       <= state_d;
            src_ip_q      <= src_ip_d;
            dst_ip_q      <= dst_ip_d;
            tot_len_q     <= tot_len_d;
            carry_q       <= carry_d;
            carry_bytes_q <= carry_bytes_d;
        end
    end
endmodule

// File: tb/tb_rx_tcp_pseudo_hdr_prepend.sv
// tb/tb_rx_tcp_pseudo_hdr_prepend.sv - directed and random-stall checks of the pseudo header prepender
module tb_rx_tcp_pseudo_hdr_prepend;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         hdr_val, hdr_rdy;
    logic [31:0]  src_ip, dst_ip;
    logic [15:0]  tot_len;
    logic         src_val, data_rdy;
    logic [255:0] data;
    logic         last;
    logic [4:0]   pad;
    logic [255:0] tdata;
    logic [31:0]  tkeep;
    logic         tval, trdy, tlast;

    int checks = 0;
    int errors = 0;

    logic [255:0] bd[$];
    logic [31:0]  bk[$];
    logic         bl[$];
    logic         br[$];
    logic [31:0]  ph_src, ph_dst;
    logic [15:0]  ph_len;

    always #5 clk = ~clk;

    rx_tcp_pseudo_hdr_prepend dut (
        .clk                       (clk),
        .rst                       (rst),
        .src_pseudo_rx_hdr_val     (hdr_val),
        .pseudo_src_rx_hdr_rdy     (hdr_rdy),
        .src_pseudo_rx_src_ip      (src_ip),
        .src_pseudo_rx_dst_ip      (dst_ip),
        .src_pseudo_rx_tcp_tot_len (tot_len),
        .src_pseudo_rx_data_val    (src_val),
        .pseudo_src_rx_data_rdy    (data_rdy),
        .src_pseudo_rx_data        (data),
        .src_pseudo_rx_last        (last),
        .src_pseudo_rx_padbytes    (pad),
        .pseudo_dst_tdata          (tdata),
        .pseudo_dst_tkeep          (tkeep),
        .pseudo_dst_tval           (tval),
        .dst_pseudo_trdy           (trdy),
        .pseudo_dst_tlast          (tlast)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input int len, input logic [7:0] seed, input int li);
        logic [255:0] d;
        for (int k = 0; k < 32; k++) begin
            int idx = li * 32 + k;
            d[255-8*k -: 8] = (idx < len) ? 8'(int'(seed) + idx) : 8'hEE;
        end
        return d;
    endfunction

    task automatic run_seg(input logic [31:0] s_ip, input logic [31:0] d_ip, input int len,
                           input logic [7:0] seed, input bit rnd, input bit skip_hdr, input bit pre_hdr);
        logic [7:0]   got[$];
        logic [7:0]   exp[$];
        logic [95:0]  ph;
        logic [255:0] sv_data;
        logic [31:0]  sv_keep;
        logic         sv_last;
        int nlines, li, cyc, t, tail_stall, first_bad;
        bit done, hold, acc, stall_bad, zero_bad, keep_bad;

        ph = {s_ip, d_ip, 8'h00, 8'h06, 16'(len)};
        for (int k = 0; k < 12; k++) exp.push_back(ph[95-8*k -: 8]);
        for (int j = 0; j < len; j++) exp.push_back(8'(int'(seed) + j));
        nlines = (len + 31) / 32;
        bd.delete(); bk.delete(); bl.delete(); br.delete();

        if (!skip_hdr) begin
            @(negedge clk);
            hdr_val = 1'b1; src_ip = s_ip; dst_ip = d_ip; tot_len = 16'(len);
            src_val = 1'b0; trdy = 1'b0;
            #1;
            t = 0;
            while (!hdr_rdy && t < 50) begin
                @(negedge clk); #1; t++;
            end
            chk("hdr_wait", hdr_rdy, 1'b1);
            @(posedge clk);
        end

        li = 0; cyc = 0; done = 0; hold = 0; tail_stall = 0;
        stall_bad = 0; zero_bad = 0; keep_bad = 0;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            if (pre_hdr && li == nlines) begin
                hdr_val = 1'b1; src_ip = ph_src; dst_ip = ph_dst; tot_len = ph_len;
            end else begin
                hdr_val = 1'b0;
            end
            if (!hold) src_val = (li < nlines) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            if (li < nlines) begin
                data = mk_line(len, seed, li);
                last = (li == nlines - 1);
                pad  = last ? 5'(nlines * 32 - len) : 5'd0;
            end
            if (pre_hdr && li == nlines && tail_stall < 2) begin
                trdy = 1'b0; tail_stall++;
            end else begin
                trdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            end
            #1;
            if (pre_hdr && li == nlines) chk("hdr_rdy_in_tail", hdr_rdy, 1'b0);
            if (hold && (tdata !== sv_data || tkeep !== sv_keep || tlast !== sv_last)) stall_bad = 1;
            hold = tval && !trdy;
            sv_data = tdata; sv_keep = tkeep; sv_last = tlast;
            if (tval && trdy) begin
                bd.push_back(tdata); bk.push_back(tkeep); bl.push_back(tlast); br.push_back(data_rdy);
                for (int k = 0; k < 32; k++) begin
                    if (tkeep[31-k]) got.push_back(tdata[255-8*k -: 8]);
                    else if (tdata[255-8*k -: 8] !== 8'h00) zero_bad = 1;
                end
                if (!tlast && tkeep !== 32'hFFFFFFFF) keep_bad = 1;
                if (tlast) done = 1;
            end
            acc = src_val && data_rdy;
            @(posedge clk);
            if (acc) li++;
            cyc++;
        end

        chk("seg_done", done, 1'b1);
        chk("byte_count", got.size(), exp.size());
        first_bad = -1;
        for (int j = 0; j < exp.size() && j < got.size(); j++)
            if (first_bad < 0 && got[j] !== exp[j]) first_bad = j;
        chk("stream_first_bad_idx", first_bad, -1);
        chk("unused_bytes_zero", zero_bad, 1'b0);
        chk("nonlast_keep_full", keep_bad, 1'b0);
        chk("stall_stable", stall_bad, 1'b0);
    endtask

    initial begin
        hdr_val = 0; src_ip = 0; dst_ip = 0; tot_len = 0;
        src_val = 0; data = 0; last = 0; pad = 0; trdy = 0;
        ph_src = 0; ph_dst = 0; ph_len = 0;

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_tval", tval, 1'b0);
        chk("rst_tlast", tlast, 1'b0);
        chk("rst_tdata", tdata, 256'h0);
        chk("rst_tkeep", tkeep, 32'h0);
        chk("rst_data_rdy", data_rdy, 1'b0);
        chk("rst_hdr_rdy", hdr_rdy, 1'b1);
        rst = 1'b0;

        run_seg(32'h0A000001, 32'h0A000002, 20, 8'h10, 0, 0, 0);
        chk("s1_beats", bd.size(), 1);
        chk("s1_keep", bk[0], 32'hFFFFFFFF);
        chk("s1_last", bl[0], 1'b1);
        chk("s1_hdr", bd[0][255:160], 96'h0A000001_0A000002_0006_0014);
        chk("s1_body", bd[0][159:0], 160'h10111213_14151617_18191A1B_1C1D1E1F_20212223);

        run_seg(32'h0A000001, 32'h0A000002, 40, 8'h00, 0, 0, 0);
        chk("s2_beats", bd.size(), 2);
        chk("s2_keep0", bk[0], 32'hFFFFFFFF);
        chk("s2_last0", bl[0], 1'b0);
        chk("s2_data1", bd[1], 256'h14151617_18191A1B_1C1D1E1F_20212223_24252627_00000000_00000000_00000000);
        chk("s2_keep1", bk[1], 32'hFFFFF000);
        chk("s2_last1", bl[1], 1'b1);

        run_seg(32'h0A000001, 32'h0A000002, 64, 8'h40, 0, 0, 0);
        chk("s3_beats", bd.size(), 3);
        chk("s3_keep1", bk[1], 32'hFFFFFFFF);
        chk("s3_data1_hi", bd[1][255:160], 96'h5455565758595A5B5C5D5E5F);
        chk("s3_data2", bd[2], 256'h74757677_78797A7B_7C7D7E7F_00000000_00000000_00000000_00000000_00000000);
        chk("s3_keep2", bk[2], 32'hFFF00000);
        chk("s3_last2", bl[2], 1'b1);
        chk("s3_data_rdy_tail", br[2], 1'b0);

        ph_src = 32'hC0A80001; ph_dst = 32'hC0A80002; ph_len = 16'd20;
        run_seg(32'h0A000003, 32'h0A000004, 64, 8'h80, 0, 0, 1);
        @(negedge clk); #1;
        chk("hdr_rdy_after_tail", hdr_rdy, 1'b1);
        @(posedge clk);
        run_seg(ph_src, ph_dst, 20, 8'h10, 0, 1, 0);
        chk("s5_beats", bd.size(), 1);
        chk("s5_hdr", bd[0][255:160], 96'hC0A80001_C0A80002_0006_0014);

        @(negedge clk);
        hdr_val = 1'b1; src_ip = 32'h0A000001; dst_ip = 32'h0A000002; tot_len = 16'd100;
        src_val = 1'b0; trdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        hdr_val = 1'b0; src_val = 1'b1; data = mk_line(100, 8'h00, 0); last = 1'b0; pad = 5'd0;
        @(posedge clk);
        @(negedge clk);
        data = mk_line(100, 8'h00, 1);
        #1;
        chk("body_carry", tdata[255:160], 96'h1415161718191A1B1C1D1E1F);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; src_val = 1'b0;
        #1;
        chk("rst_mid_tval", tval, 1'b0);
        chk("rst_mid_data_rdy", data_rdy, 1'b0);
        chk("rst_mid_hdr_rdy", hdr_rdy, 1'b1);
        run_seg(32'h0A000001, 32'h0A000002, 20, 8'h10, 0, 0, 0);
        chk("s6_beats", bd.size(), 1);
        chk("s6_keep", bk[0], 32'hFFFFFFFF);
        chk("s6_data", bd[0], {96'h0A000001_0A000002_0006_0014,
                               160'h10111213_14151617_18191A1B_1C1D1E1F_20212223});

        for (int s = 0; s < 200; s++) begin
            run_seg($urandom, $urandom, $urandom_range(20, 1500), 8'($urandom), 1, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rx_tcp_pseudo_hdr_prepend.md
Name: rx_tcp_pseudo_hdr_prepend

Overview:
- Sits between the RX IP-layer demux and the RX TCP checksum engine.
- Takes an IP-layer header handshake (src/dst IP, TCP length) and the TCP segment as a MAC-interface stream.
- Emits one AXI-style stream per segment: the 12-byte checksum pseudo header, then the TCP segment, byte-realigned.
- This is the stream format that the checksum engine and the TCP format stage downstream of it expect.

Parameters:
DATA_WIDTH, 256, stream width in bits; must equal `MAC_INTERFACE_W and be > 96.
KEEP_WIDTH, DATA_WIDTH/8, byte-enable width; tkeep MSB = byte 0.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
src_pseudo_rx_hdr_val  input  1  segment header valid
pseudo_src_rx_hdr_rdy  output  1  header ready
src_pseudo_rx_src_ip  input  `IP_ADDR_W  source IP
src_pseudo_rx_dst_ip  input  `IP_ADDR_W  destination IP
src_pseudo_rx_tcp_tot_len  input  `TOT_LEN_W  TCP header+payload bytes
src_pseudo_rx_data_val  input  1  segment data valid
pseudo_src_rx_data_rdy  output  1  data ready
src_pseudo_rx_data  input  DATA_WIDTH  segment bytes, byte 0 at MSB
src_pseudo_rx_last  input  1  final segment line
src_pseudo_rx_padbytes  input  `MAC_PADBYTES_W  invalid trailing bytes on last line
pseudo_dst_tdata  output  DATA_WIDTH  output line
pseudo_dst_tkeep  output  KEEP_WIDTH  byte enables, MSB-first
pseudo_dst_tval  output  1  output valid
dst_pseudo_trdy  input  1  output ready
pseudo_dst_tlast  output  1  final output line

Behaviour:
- Let B = KEEP_WIDTH (32) and P = 12.
- Pseudo header, MSB-first: {src_ip[31:0], dst_ip[31:0], 8'h00, 8'h06, tot_len[15:0]}.
- Reset:
  - state = IDLE; header, carry and carry_bytes registers cleared.
  - pseudo_dst_tval = 0, tlast = 0, tdata = 0, tkeep = 0.
  - pseudo_src_rx_data_rdy = 0; pseudo_src_rx_hdr_rdy = 1 (IDLE).
- Reset mid-segment: the next cycle is IDLE and the partial segment is abandoned. Upstream is reset alongside.
- Every segment has at least one data line, since the TCP header is at least 20 bytes.
- On the last input line, valid bytes V = B - padbytes. padbytes = 0 means a full line.
- Output data, tkeep and tlast are combinational from state/registers/input. No registered output stage, so latency is 0 cycles in FIRST/BODY.
- In FIRST/BODY: pseudo_src_rx_data_rdy = dst_pseudo_trdy and pseudo_dst_tval = src_pseudo_rx_data_val. An input beat is accepted only when an output beat is accepted.
- States:
  - IDLE:
    - hdr_rdy = 1; no data accepted; tval = 0.
    - On hdr_val: latch src_ip, dst_ip, tot_len -> FIRST.
  - FIRST:
    - hdr_rdy = 0.
    - tdata = {pseudo header (P bytes), input bytes 0..B-P-1}.
    - On handshake: carry <= input bytes B-P..B-1.
    - Not last -> BODY.
    - Last and V <= B-P: tlast = 1, tkeep = top P+V bits set -> IDLE.
    - Last and V > B-P: tkeep all ones, tlast = 0, carry_bytes <= V-(B-P) -> TAIL.
  - BODY:
    - tdata = {carry, input bytes 0..B-P-1}.
    - Handshake, last and TAIL rules are identical to FIRST.
    - Not last: stay in BODY and reload carry.
  - TAIL:
    - data_rdy = 0; tval = 1.
    - tdata = {carry, zeros}; tkeep = top carry_bytes bits set; tlast = 1.
    - On trdy -> IDLE.
- Non-last output beats always have tkeep all ones.
- Unused tdata bytes are driven 0.
- Stall (val & !rdy on either side): all registers hold. Output data/keep/last stay stable while tval=1 and trdy=0.
- Back-to-back segments: a header is accepted only in IDLE, so there is a one-cycle bubble between segments (accepted cost).
- Header valid during FIRST/BODY/TAIL is ignored (hdr_rdy = 0) until IDLE.
- tot_len is passed through unchecked against the stream length. The checksum engine catches mismatches.
- Illegal state: outputs X, next state X.

Test Plan:
- Header-only segment: src=0x0A000001, dst=0x0A000002, tot_len=20; one line with padbytes=12, last.
  -> One beat, tkeep=0xFFFFFFFF, tlast=1.
  -> tdata[255:160]=0x0A000001_0A000002_0006_0014; tdata[159:0] = input bytes 0..19.
- tot_len=40: two lines, the second with padbytes=24.
  -> Two beats. Beat 2 = {in1 bytes 20..31, in2 bytes 0..7, zeros}, tkeep=0xFFFFF000, tlast=1.
- tot_len=64: two full lines (padbytes=0).
  -> Three beats; beat 3 comes from TAIL.
  -> Beat 3: tkeep=0xFFF00000, tdata[255:160] = in2 bytes 20..31, tlast=1.
  -> Input is not ready during beat 3.
- Random dst_pseudo_trdy (50%) over 200 segments with random tot_len 20..1500.
  -> Byte stream equals pseudo header ++ segment.
  -> Sum of tkeep bits = tot_len+12; no beat dropped or duplicated; outputs stable under stall.
- Header offered during TAIL.
  -> hdr_rdy=0 until the TAIL beat is accepted; header accepted the cycle after, in IDLE.
- rst asserted for 1 cycle while in BODY.
  -> Next cycle: tval=0, data_rdy=0, hdr_rdy=1.
  -> A fresh 20-byte segment then passes exactly as in scenario 1.
